// File: rtl/lif_spike_decoder.sv
// lif_spike_decoder: turns the LIF neuron spike train into per-window spike
// counts and last inter-spike intervals, presented through a valid/ready
// result register. Back-to-back windows of window_len+1 cycles each.
// Optional build macro: LIF_SPIKE_DEC_REFRACT_EN -- after a counted spike,
// further spikes are ignored for REFRACT cycles.
module lif_spike_decoder #(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = 8,
  parameter int ISI_W    = 8,
  parameter int REFRACT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [COUNT_W-1:0]  count_out,
  output logic [ISI_W-1:0]    isi_out,
  output logic                sat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                drop
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_t;

  // Saturating increment; MSB of the result flags an attempted overflow.
  function automatic logic [COUNT_W:0] cnt_inc(input logic [COUNT_W-1:0] v);
    logic [COUNT_W:0] r;
    if (&v) r = {1'b1, v};
    else    r = {1'b0, v + COUNT_W'(1'b1)};
    return r;
  endfunction

  // Saturating increment for the interval counter; MSB flags overflow.
  function automatic logic [ISI_W:0] isi_inc(input logic [ISI_W-1:0] v);
    logic [ISI_W:0] r;
    if (&v) r = {1'b1, v};
    else    r = {1'b0, v + ISI_W'(1'b1)};
    return r;
  endfunction

  state_t              state_r, state_nxt_s;
  logic                start_s, run_s, commit_s, accept_s;
  logic [WINDOW_W-1:0] cyc_r, win_len_r;
  logic [COUNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic                cnt_sat_r, cnt_sat_nxt_s;
  logic [ISI_W-1:0]    isi_r, isi_nxt_s, since_r, since_nxt_s;
  logic                isi_sat_r, isi_sat_nxt_s, since_ovf_r, since_ovf_nxt_s;
  logic                seen_r, seen_nxt_s;
  logic [COUNT_W:0]    cnt_inc_s;
  logic [ISI_W:0]      since_inc_s;

`ifdef LIF_SPIKE_DEC_REFRACT_EN
  localparam int REF_W = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  logic [REF_W-1:0] refr_r;

  // Spikes count only outside the refractory period of the last counted spike.
  always_comb begin
    accept_s = spike_in && run_s && (refr_r == {REF_W{1'b0}});
  end

  // Refractory timer: loaded on a counted spike, cleared at every window start.
  always_ff @(posedge clk) begin
    if (rst)                              refr_r <= {REF_W{1'b0}};
    else if (start_s || commit_s || !run_s) refr_r <= {REF_W{1'b0}};
    else if (accept_s)                    refr_r <= REF_W'(REFRACT);
    else if (refr_r != {REF_W{1'b0}})     refr_r <= refr_r - REF_W'(1'b1);
    else                                  refr_r <= refr_r;
  end
`else
  logic unused_refract_s;
  assign unused_refract_s = (REFRACT > 32'sd0) ? 1'b1 : 1'b0;

  // Every high spike_in cycle inside a running window is counted.
  always_comb begin
    accept_s = spike_in && run_s;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next state: en alone decides between idling and counting.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE:  if (en) state_nxt_s = ST_COUNT; else state_nxt_s = ST_IDLE;
      ST_COUNT: if (en) state_nxt_s = ST_COUNT; else state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM control strobes: window start, active counting cycle, window commit.
  always_comb begin
    start_s  = 1'b0;
    run_s    = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: start_s = en;
      ST_COUNT: begin
        if (en) begin
          run_s    = 1'b1;
          commit_s = (cyc_r == win_len_r);
        end else begin
          run_s    = 1'b0;
          commit_s = 1'b0;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  // Window statistics after this cycle's spike, also used as the commit value.
  always_comb begin
    cnt_inc_s       = cnt_inc(cnt_r);
    since_inc_s     = isi_inc(since_r);
    cnt_nxt_s       = cnt_r;
    cnt_sat_nxt_s   = cnt_sat_r;
    isi_nxt_s       = isi_r;
    isi_sat_nxt_s   = isi_sat_r;
    seen_nxt_s      = seen_r;
    since_nxt_s     = since_r;
    since_ovf_nxt_s = since_ovf_r;
    if (accept_s) begin
      cnt_nxt_s     = cnt_inc_s[COUNT_W-1:0];
      cnt_sat_nxt_s = cnt_sat_r | cnt_inc_s[COUNT_W];
      if (seen_r) begin
        isi_nxt_s     = since_r;
        isi_sat_nxt_s = since_ovf_r;
      end else begin
        isi_nxt_s     = isi_r;
        isi_sat_nxt_s = isi_sat_r;
      end
      seen_nxt_s      = 1'b1;
      since_nxt_s     = ISI_W'(1'b1);
      since_ovf_nxt_s = 1'b0;
    end else begin
      since_nxt_s     = since_inc_s[ISI_W-1:0];
      since_ovf_nxt_s = since_ovf_r | since_inc_s[ISI_W];
    end
  end

  // Window counters: restart on start/commit, advance while running, clear otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_r <= '0; win_len_r <= '0; cnt_r <= '0; cnt_sat_r <= 1'b0;
      isi_r <= '0; isi_sat_r <= 1'b0; since_r <= '0; since_ovf_r <= 1'b0;
      seen_r <= 1'b0;
    end else if (start_s || commit_s) begin
      cyc_r <= '0; win_len_r <= window_len; cnt_r <= '0; cnt_sat_r <= 1'b0;
      isi_r <= '0; isi_sat_r <= 1'b0; since_r <= '0; since_ovf_r <= 1'b0;
      seen_r <= 1'b0;
    end else if (run_s) begin
      cyc_r <= cyc_r + WINDOW_W'(1'b1);
      cnt_r <= cnt_nxt_s; cnt_sat_r <= cnt_sat_nxt_s;
      isi_r <= isi_nxt_s; isi_sat_r <= isi_sat_nxt_s;
      since_r <= since_nxt_s; since_ovf_r <= since_ovf_nxt_s;
      seen_r <= seen_nxt_s;
    end else begin
      cyc_r <= '0; win_len_r <= win_len_r; cnt_r <= '0; cnt_sat_r <= 1'b0;
      isi_r <= '0; isi_sat_r <= 1'b0; since_r <= '0; since_ovf_r <= 1'b0;
      seen_r <= 1'b0;
    end
  end

  // Result register: load on commit unless the held result is still unread.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_out <= '0; isi_out <= '0; sat <= 1'b0; out_valid <= 1'b0; drop <= 1'b0;
    end else if (commit_s && (!out_valid || out_ready)) begin
      count_out <= cnt_nxt_s;
      isi_out   <= isi_nxt_s;
      sat       <= cnt_sat_nxt_s | isi_sat_nxt_s;
      out_valid <= 1'b1;
    end else if (commit_s) begin
      drop <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_lif_spike_decoder.sv
// Testbench for lif_spike_decoder: table-driven windows, hand-written
// handshake/abort/saturation sequences and a randomized run, all compared
// every cycle against a spike-time based reference model.
module tb_lif_spike_decoder;

`ifdef LIF_SPIKE_DEC_REFRACT_EN
  localparam int REFR_EFF = 2;
`else
  localparam int REFR_EFF = 0;
`endif

  logic       clk, rst, en, spike_in, out_ready;
  logic [7:0] window_len;
  logic [7:0] count_out, isi_out;
  logic       sat, out_valid, drop;

  int n_checks = 0;
  int n_fail   = 0;

  lif_spike_decoder dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .window_len(window_len),
    .count_out(count_out), .isi_out(isi_out), .sat(sat), .out_valid(out_valid),
    .out_ready(out_ready), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: window position and accepted spike times.
  bit m_run;
  int m_t, m_wl, m_last_acc;
  int q[$];
  bit m_ov, m_sat, m_drop;
  int m_cnt, m_isi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit commit = 0;
    bit xfer = m_ov && out_ready;
    int n, rc, ri;
    bit rs;
    if (rst) begin
      m_run = 0; q.delete(); m_ov = 0; m_cnt = 0; m_isi = 0; m_sat = 0; m_drop = 0;
    end else begin
      rc = 0; ri = 0; rs = 0;
      if (!m_run) begin
        if (en) begin m_run = 1; m_t = 0; m_wl = window_len; q.delete(); m_last_acc = -1000; end
      end else if (!en) begin
        m_run = 0; q.delete();
      end else begin
        if (spike_in && (m_t - m_last_acc > REFR_EFF)) begin q.push_back(m_t); m_last_acc = m_t; end
        if (m_t == m_wl) begin
          commit = 1;
          n  = q.size();
          rc = (n > 255) ? 255 : n;
          rs = (n > 255);
          ri = (n >= 2) ? q[n-1] - q[n-2] : 0;
          if (ri > 255) begin ri = 255; rs = 1; end
          m_t = 0; m_wl = window_len; q.delete(); m_last_acc = -1000;
        end else begin
          m_t++;
        end
      end
      if (commit) begin
        if (!m_ov || out_ready) begin m_ov = 1; m_cnt = rc; m_isi = ri; m_sat = rs; end
        else m_drop = 1;
      end else if (xfer) begin
        m_ov = 0;
      end
    end
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("m_out_valid", out_valid, m_ov);
    check("m_drop", drop, m_drop);
    if (m_ov) begin
      check("m_count_out", count_out, m_cnt);
      check("m_isi_out", isi_out, m_isi);
      check("m_sat", sat, m_sat);
    end
  endtask

  task automatic drive_window(input int wl, input logic [15:0] mask, input bit from_idle);
    en = 1'b1; window_len = 8'(wl); spike_in = 1'b0;
    if (from_idle) step();
    for (int c = 0; c <= wl; c++) begin
      spike_in = (c < 16) ? mask[c] : 1'b0;
      step();
    end
    spike_in = 1'b0;
  endtask

  task automatic go_idle();
    en = 1'b0; spike_in = 1'b0; step();
  endtask

  typedef struct {
    int          wl;
    logic [15:0] mask;
    int          ec;
    int          ei;
    bit          es;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{9,  16'h0224, 3, 4,  1'b0};
    vecs[1] = '{15, 16'h0010, 1, 0,  1'b0};
    vecs[2] = '{0,  16'h0001, 1, 0,  1'b0};
    vecs[3] = '{0,  16'h0000, 0, 0,  1'b0};
    vecs[4] = '{7,  16'h0081, 2, 7,  1'b0};
    vecs[5] = '{15, 16'h8011, 3, 11, 1'b0};
`ifdef LIF_SPIKE_DEC_REFRACT_EN
    vecs[6] = '{7,  16'h001E, 2, 3,  1'b0};
`else
    vecs[6] = '{7,  16'h001E, 4, 1,  1'b0};
`endif

    rst = 1'b1; en = 1'b0; spike_in = 1'b0; out_ready = 1'b1; window_len = 8'd0;
    step(); step();
    check("rst_count", count_out, 32'd0);
    check("rst_isi", isi_out, 32'd0);
    check("rst_sat", sat, 32'd0);
    check("rst_valid", out_valid, 32'd0);
    check("rst_drop", drop, 32'd0);
    rst = 1'b0;

    // Table of single windows, each started from IDLE with out_ready high.
    for (int i = 0; i < 7; i++) begin
      drive_window(vecs[i].wl, vecs[i].mask, 1'b1);
      check("vec_valid", out_valid, 32'd1);
      check("vec_count", count_out, vecs[i].ec);
      check("vec_isi", isi_out, vecs[i].ei);
      check("vec_sat", sat, vecs[i].es);
      go_idle();
    end
    go_idle();

    // Back-pressure over two windows: first result held, second dropped.
    out_ready = 1'b0;
    drive_window(3, 16'h0002, 1'b1);
    check("bp_valid1", out_valid, 32'd1);
    check("bp_count1", count_out, 32'd1);
    check("bp_drop1", drop, 32'd0);
    drive_window(3, 16'h0004, 1'b0);
    check("bp_count2", count_out, 32'd1);
    check("bp_drop2", drop, 32'd1);
    out_ready = 1'b1;
    go_idle();
    go_idle();
    go_idle();
    check("bp_valid_after", out_valid, 32'd0);
    check("bp_drop_sticky", drop, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("bp_drop_rst", drop, 32'd0);

    // Continuous spiking across a maximum-length window.
    en = 1'b1; window_len = 8'd255; spike_in = 1'b0; step();
    spike_in = 1'b1;
    for (int c = 0; c < 256; c++) step();
    spike_in = 1'b0;
    check("cont_valid", out_valid, 32'd1);
`ifdef LIF_SPIKE_DEC_REFRACT_EN
    check("cont_count", count_out, 32'd86);
    check("cont_isi", isi_out, 32'd3);
    check("cont_sat", sat, 32'd0);
`else
    check("cont_count", count_out, 32'd255);
    check("cont_isi", isi_out, 32'd1);
    check("cont_sat", sat, 32'd1);
`endif
    go_idle();
    go_idle();

    // Abort mid-window, then a clean window with no spikes.
    en = 1'b1; window_len = 8'd9; spike_in = 1'b0; step();
    for (int c = 0; c < 5; c++) begin
      spike_in = (c == 1 || c == 3) ? 1'b1 : 1'b0;
      step();
    end
    spike_in = 1'b0;
    go_idle(); go_idle(); go_idle();
    check("abort_no_commit", out_valid, 32'd0);
    drive_window(9, 16'h0000, 1'b1);
    check("abort_valid", out_valid, 32'd1);
    check("abort_count", count_out, 32'd0);
    check("abort_isi", isi_out, 32'd0);
    go_idle();

    // Randomized traffic, checked every cycle against the model.
    for (int k = 0; k < 5000; k++) begin
      rst        = ($urandom_range(0, 399) == 0);
      en         = ($urandom_range(0, 19) != 0);
      spike_in   = ($urandom_range(0, 2) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      window_len = 8'($urandom_range(0, 6));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
